// File: rtl/wb_write_arbiter_if.sv
// Bus bundle for the writeback arbiter: two result producers and the register-file write port.
interface wb_write_arbiter_if #(
   parameter int unsigned RSIZE = 32
);
   logic             alu_valid;
   logic             alu_ready;
   logic [4:0]       alu_idx;
   logic [RSIZE-1:0] alu_data;
   logic             mem_valid;
   logic             mem_ready;
   logic [4:0]       mem_idx;
   logic [RSIZE-1:0] mem_data;
   logic [4:0]       write_idx;
   logic [RSIZE-1:0] write_data;
   logic             rwrite;
   logic             wb_busy;

   modport slave (
      input  alu_valid, alu_idx, alu_data, mem_valid, mem_idx, mem_data,
      output alu_ready, mem_ready, write_idx, write_data, rwrite, wb_busy
   );

   modport master (
      output alu_valid, alu_idx, alu_data, mem_valid, mem_idx, mem_data,
      input  alu_ready, mem_ready, write_idx, write_data, rwrite, wb_busy
   );
endinterface

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: queues ALU and load results in small FIFOs and issues one
// register-file write per cycle, favouring loads but never starving the ALU.
module wb_write_arbiter #(
   parameter int unsigned RSIZE        = 32,
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input logic                clk,
   input logic                rst,
   wb_write_arbiter_if.slave  bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] FULL  = CW'(DEPTH);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   // Source 0 is the ALU pipe, source 1 the load pipe.
   logic [4:0]       r_idx  [2][DEPTH];
   logic [RSIZE-1:0] r_data [2][DEPTH];
   logic [PW-1:0]    r_wp   [2];
   logic [PW-1:0]    r_rp   [2];
   logic [CW-1:0]    r_cnt  [2];
   logic [SW-1:0]    r_starve;
   logic             r_rwrite;
   logic [4:0]       r_write_idx;
   logic [RSIZE-1:0] r_write_data;

   logic             w_valid   [2];
   logic [4:0]       w_in_idx  [2];
   logic [RSIZE-1:0] w_in_data [2];
   logic             w_ready   [2];
   logic             w_push    [2];
   logic             w_pop     [2];
   logic             w_ne      [2];
   logic             w_grant_alu;
   logic             w_grant;
   logic [4:0]       w_head_idx;
   logic [RSIZE-1:0] w_head_data;

   always_comb begin
      w_valid[0]   = bus.alu_valid;
      w_valid[1]   = bus.mem_valid;
      w_in_idx[0]  = bus.alu_idx;
      w_in_idx[1]  = bus.mem_idx;
      w_in_data[0] = bus.alu_data;
      w_in_data[1] = bus.mem_data;
      for (int unsigned s = 0; s < 2; s++) begin
         w_ready[s] = !rst && (r_cnt[s] != FULL);
         w_push[s]  = w_valid[s] && w_ready[s];
         w_ne[s]    = (r_cnt[s] != '0);
      end
   end

   // Loads win ties until the ALU has been passed over STARVE_LIMIT times.
   always_comb begin
      w_grant_alu = w_ne[0] && (!w_ne[1] || (r_starve == LIMIT));
      w_grant     = w_ne[0] || w_ne[1];
      w_pop[0]    = w_grant_alu;
      w_pop[1]    = w_ne[1] && !w_grant_alu;
      w_head_idx  = w_grant_alu ? r_idx[0][r_rp[0]]  : r_idx[1][r_rp[1]];
      w_head_data = w_grant_alu ? r_data[0][r_rp[0]] : r_data[1][r_rp[1]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < 2; s++) begin
            r_wp[s]  <= '0;
            r_rp[s]  <= '0;
            r_cnt[s] <= '0;
         end
         r_starve     <= '0;
         r_rwrite     <= 1'b0;
         r_write_idx  <= '0;
         r_write_data <= '0;
      end else begin
         for (int unsigned s = 0; s < 2; s++) begin
            if (w_push[s]) begin
               r_idx[s][r_wp[s]]  <= w_in_idx[s];
               r_data[s][r_wp[s]] <= w_in_data[s];
               r_wp[s]            <= r_wp[s] + 1'b1;
            end
            if (w_pop[s])
               r_rp[s] <= r_rp[s] + 1'b1;
            case ({w_push[s], w_pop[s]})
               2'b10:   r_cnt[s] <= r_cnt[s] + 1'b1;
               2'b01:   r_cnt[s] <= r_cnt[s] - 1'b1;
               default: r_cnt[s] <= r_cnt[s];
            endcase
         end

         if (!w_ne[0] || w_grant_alu)
            r_starve <= '0;
         else if (r_starve != LIMIT)
            r_starve <= r_starve + 1'b1;

         // Index 0 entries still consume a grant but never write.
         if (w_grant) begin
            r_write_idx  <= w_head_idx;
            r_write_data <= w_head_data;
            r_rwrite     <= (w_head_idx != 5'd0);
         end else begin
            r_rwrite <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.alu_ready  = w_ready[0];
      bus.mem_ready  = w_ready[1];
      bus.write_idx  = r_write_idx;
      bus.write_data = r_write_data;
      bus.rwrite     = r_rwrite;
      bus.wb_busy    = !rst && (w_ne[0] || w_ne[1] || r_rwrite);
   end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_write_arbiter;
   localparam int DEPTH = 2;
   localparam int LIMIT = 3;

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   wb_write_arbiter_if #(.RSIZE(32)) bus ();

   wb_write_arbiter #(.RSIZE(32), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model state
   ent_t        aq[$];
   ent_t        mq[$];
   int          starve = 0;
   logic        m_rw   = 1'b0;
   logic [4:0]  m_idx  = '0;
   logic [31:0] m_data = '0;
   bit          a_acc  = 0;
   bit          m_acc  = 0;

   always @(posedge clk) begin
      ent_t g;
      bit   galu;
      if (rst) begin
         aq.delete();
         mq.delete();
         starve = 0;
         m_rw   = 1'b0;
         m_idx  = '0;
         m_data = '0;
         a_acc  = 0;
         m_acc  = 0;
      end else begin
         a_acc = bus.alu_valid && (aq.size() != DEPTH);
         m_acc = bus.mem_valid && (mq.size() != DEPTH);
         galu  = (aq.size() > 0) && ((mq.size() == 0) || (starve == LIMIT));
         if (aq.size() == 0 || galu) starve = 0;
         else if (starve < LIMIT) starve++;
         if (aq.size() > 0 || mq.size() > 0) begin
            g      = galu ? aq.pop_front() : mq.pop_front();
            m_rw   = (g.idx != 5'd0);
            m_idx  = g.idx;
            m_data = g.data;
         end else begin
            m_rw = 1'b0;
         end
         if (a_acc) aq.push_back('{idx: bus.alu_idx, data: bus.alu_data});
         if (m_acc) mq.push_back('{idx: bus.mem_idx, data: bus.mem_data});
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, after inputs for the cycle settle
   always @(negedge clk) begin
      #1;
      check("alu_ready",  32'(bus.alu_ready), 32'(!rst && aq.size() != DEPTH));
      check("mem_ready",  32'(bus.mem_ready), 32'(!rst && mq.size() != DEPTH));
      check("rwrite",     32'(bus.rwrite),    32'(m_rw));
      check("write_idx",  32'(bus.write_idx), 32'(m_idx));
      check("write_data", bus.write_data,     m_data);
      check("wb_busy",    32'(bus.wb_busy),
            32'(!rst && (aq.size() != 0 || mq.size() != 0 || m_rw)));
   end

   task automatic idle();
      bus.alu_valid = 1'b0;
      bus.mem_valid = 1'b0;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      logic [4:0] got[$];
      logic [4:0] star_exp[8];
      int         n;
      bit         sawfull;

      bus.alu_valid = 1'b1; bus.alu_idx = 5'd3; bus.alu_data = 32'h1;
      bus.mem_valid = 1'b1; bus.mem_idx = 5'd4; bus.mem_data = 32'h2;
      rst = 1'b1;

      // Reset held with both sources offering
      repeat (2) begin
         cyc(); #2;
         check("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
         check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
         check("rst_rwrite",    32'(bus.rwrite),    32'd0);
         check("rst_idx",       32'(bus.write_idx), 32'd0);
         check("rst_data",      bus.write_data,     32'd0);
         check("rst_busy",      32'(bus.wb_busy),   32'd0);
      end
      cyc(); rst = 1'b0; idle(); #2;
      check("rel_alu_ready", 32'(bus.alu_ready), 32'd1);
      check("rel_mem_ready", 32'(bus.mem_ready), 32'd1);

      // Single ALU write: two-edge latency, one-cycle pulse
      cyc(); bus.alu_valid = 1'b1; bus.alu_idx = 5'd5; bus.alu_data = 32'hDEADBEEF;
      cyc(); idle(); #2;
      check("single_early", 32'(bus.rwrite), 32'd0);
      cyc(); #2;
      check("single_rw",   32'(bus.rwrite),    32'd1);
      check("single_idx",  32'(bus.write_idx), 32'd5);
      check("single_data", bus.write_data,     32'hDEADBEEF);
      cyc(); #2;
      check("single_end", 32'(bus.rwrite), 32'd0);

      // Register 0 load is consumed without a write
      cyc(); bus.mem_valid = 1'b1; bus.mem_idx = 5'd0; bus.mem_data = 32'h1234;
      cyc(); idle(); #2;
      check("zero_busy_q", 32'(bus.wb_busy), 32'd1);
      cyc(); #2;
      check("zero_rw",   32'(bus.rwrite),  32'd0);
      check("zero_busy", 32'(bus.wb_busy), 32'd0);

      // Concurrent push/pop on ALU FIFO holding one entry
      cyc(); bus.alu_valid = 1'b1; bus.alu_idx = 5'd11; bus.alu_data = 32'hB;
      cyc(); bus.alu_idx = 5'd12; bus.alu_data = 32'hC;
      cyc(); idle(); #2;
      check("pp_ready", 32'(bus.alu_ready), 32'd1);
      check("pp_idx1",  32'(bus.write_idx), 32'd11);
      check("pp_busy",  32'(bus.wb_busy),   32'd1);
      cyc(); #2;
      check("pp_idx2",  32'(bus.write_idx), 32'd12);
      check("pp_data2", bus.write_data,     32'hC);
      repeat (2) cyc();

      // Backpressure: loads keep the mem FIFO busy while ALU offers 1,2,3 with holding
      sawfull = 0;
      n = 1;
      bus.mem_valid = 1'b1; bus.mem_idx = 5'd9; bus.mem_data = 32'h99;
      for (int c = 0; c < 60 && got.size() < 3; c++) begin
         cyc();
         if (bus.alu_valid && a_acc) n++;
         if (n <= 3) begin
            bus.alu_valid = 1'b1; bus.alu_idx = 5'(n); bus.alu_data = 32'(n);
         end else begin
            bus.alu_valid = 1'b0;
         end
         #2;
         if (!bus.alu_ready) sawfull = 1;
         if (bus.rwrite && bus.write_idx != 5'd9) got.push_back(bus.write_idx);
      end
      check("bp_count", 32'(got.size()), 32'd3);
      check("bp_full",  32'(sawfull),    32'd1);
      for (int i = 0; i < 3 && i < got.size(); i++)
         check("bp_order", 32'(got[i]), 32'(i + 1));
      idle();
      repeat (6) cyc();

      // Starvation: both continuously offered after a clean reset
      cyc(); rst = 1'b1;
      cyc(); rst = 1'b0;
      star_exp = '{5'd9, 5'd9, 5'd9, 5'd7, 5'd9, 5'd9, 5'd9, 5'd7};
      got.delete();
      bus.alu_valid = 1'b1; bus.alu_idx = 5'd7; bus.alu_data = 32'h77;
      bus.mem_valid = 1'b1; bus.mem_idx = 5'd9; bus.mem_data = 32'h99;
      for (int c = 0; c < 30 && got.size() < 8; c++) begin
         cyc(); #2;
         if (bus.rwrite) got.push_back(bus.write_idx);
      end
      check("starve_count", 32'(got.size()), 32'd8);
      for (int i = 0; i < 8 && i < got.size(); i++)
         check("starve_seq", 32'(got[i]), 32'(star_exp[i]));
      idle();
      repeat (6) cyc();

      // Random traffic with held offers and occasional mid-stream reset
      for (int c = 0; c < 1500; c++) begin
         cyc();
         rst = ($urandom_range(0, 99) == 0);
         if (!bus.alu_valid || a_acc) begin
            bus.alu_valid = ($urandom_range(0, 99) < 60);
            bus.alu_idx   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            bus.alu_data  = $urandom;
         end
         if (!bus.mem_valid || m_acc) begin
            bus.mem_valid = ($urandom_range(0, 99) < 50);
            bus.mem_idx   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            bus.mem_data  = $urandom;
         end
      end
      rst = 1'b0;
      idle();
      repeat (8) cyc();
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
